uart_rx_core: RTL and testbench



---
 rtl/uart_rx_core.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// UART receiver: 2-FF synchronised line, mid-bit sampling, runtime word/parity/stop configuration.
// Define UART_RX_PARITY_EN to build the parity state and the parity_error flag.
module uart_rx_core #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic [15:0]       clk_div,
  input  logic [4:0]        bits_per_word,
  input  logic              parity_en,
  input  logic              parity_evan_odd,
  input  logic              two_stop_bit,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              new_data,
  output logic              frame_error,
  output logic              parity_error
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP1,
    STOP2,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sync_q;
  logic        rx_s, rx_prev, fall;
  logic [15:0] div_clamped, div_q;
  logic [3:0]  bpw_clamped, nbits_m1_q;
  logic        two_stop_q;
  logic [15:0] baud_cnt, baud_nxt, bit_cnt;
  logic        sample, last_bit;
  logic [15:0] shreg;
  logic        ferr_acc;

  assign rx_s     = sync_q[1];
  assign fall     = rx_prev & ~rx_s;
  assign sample   = (baud_cnt == 16'd0);
  assign last_bit = (bit_cnt == {12'd0, nbits_m1_q});
  assign baud_nxt = sample ? (div_q - 16'd1) : (baud_cnt - 16'd1);
  assign busy     = (state_q != IDLE) && (state_q != DONE);

  // Configuration is clamped before latching so the frame never runs with a degenerate divisor or word
  always_comb begin
    div_clamped = (clk_div < 16'd4) ? 16'd4 : clk_div;
    if (bits_per_word < 5'd4) begin
      bpw_clamped = 4'd4;
    end else if (bits_per_word > 5'd15) begin
      bpw_clamped = 4'd15;
    end else begin
      bpw_clamped = bits_per_word[3:0];
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_en_q, par_odd_q, par_acc, perr_acc, parity_error_q;
  assign parity_error = parity_error_q;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = parity_en ^ parity_evan_odd;
  assign parity_error      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (fall) state_d = START;
      START: if (sample) state_d = rx_s ? IDLE : DATA;
      DATA: begin
        if (sample && last_bit) begin
`ifdef UART_RX_PARITY_EN
          state_d = par_en_q ? PARITY : STOP1;
`else
          state_d = STOP1;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (sample) state_d = STOP1;
`endif
      STOP1: if (sample) state_d = two_stop_q ? STOP2 : DONE;
      STOP2: if (sample) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: synchroniser, counters and per-frame accumulators
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= 2'b11;
      rx_prev    <= 1'b1;
      div_q      <= 16'd4;
      nbits_m1_q <= 4'd4;
      two_stop_q <= 1'b0;
      baud_cnt   <= 16'd0;
      bit_cnt    <= 16'd0;
      shreg      <= 16'd0;
      ferr_acc   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      par_acc    <= 1'b0;
      perr_acc   <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[0], rx};
      rx_prev <= rx_s;
      case (state_q)
        IDLE: begin
          if (fall) begin
            div_q      <= div_clamped;
            nbits_m1_q <= bpw_clamped;
            two_stop_q <= two_stop_bit;
            baud_cnt   <= div_clamped >> 1;
            bit_cnt    <= 16'd0;
            shreg      <= 16'd0;
            ferr_acc   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_q   <= parity_en;
            par_odd_q  <= parity_evan_odd;
            par_acc    <= 1'b0;
            perr_acc   <= 1'b0;
`endif
          end
        end
        START: begin
          baud_cnt <= baud_nxt;
          if (sample) bit_cnt <= 16'd0;
        end
        DATA: begin
          baud_cnt <= baud_nxt;
          if (sample) begin
            shreg[bit_cnt[3:0]] <= rx_s;
            bit_cnt             <= bit_cnt + 16'd1;
`ifdef UART_RX_PARITY_EN
            par_acc             <= par_acc ^ rx_s;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          baud_cnt <= baud_nxt;
          if (sample) begin
            perr_acc <= par_acc ^ rx_s ^ par_odd_q;
            bit_cnt  <= 16'd0;
          end
        end
`endif
        STOP1, STOP2: begin
          baud_cnt <= baud_nxt;
          if (sample) begin
            bit_cnt <= 16'd0;
            if (!rx_s) ferr_acc <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Results are published on the edge that enters DONE, so new_data is high exactly during DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out    <= '0;
      new_data    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      new_data <= (state_d == DONE);
      if (state_d == DONE) begin
        data_out    <= DATA_W'(shreg);
        frame_error <= ferr_acc | ~rx_s;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_error_q <= 1'b0;
    end else if (state_d == DONE) begin
      parity_error_q <= perr_acc;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed test-plan frames plus randomized frames
// checked against a frame-level reference model.
module tb_uart_rx_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] clk_div = 16'd16;
  logic [4:0]  bits_per_word = 5'd7;
  logic        parity_en = 1'b0;
  logic        parity_evan_odd = 1'b0;
  logic        two_stop_bit = 1'b0;
  logic [15:0] data_out;
  logic        busy, new_data, frame_error, parity_error;

  int checks = 0;
  int failures = 0;
  int busy_cnt = 0;
  int pulse_cnt = 0;
  logic [15:0] last_data = 16'h0;

  uart_rx_core #(.DATA_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .clk_div(clk_div),
    .bits_per_word(bits_per_word),
    .parity_en(parity_en),
    .parity_evan_odd(parity_evan_odd),
    .two_stop_bit(two_stop_bit),
    .data_out(data_out),
    .busy(busy),
    .new_data(new_data),
    .frame_error(frame_error),
    .parity_error(parity_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (new_data === 1'b1) pulse_cnt++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serialises one frame: start, nd data bits LSB first, optional parity, stop bits; scrambles config mid-frame
  task automatic apply_stimulus(input logic [15:0] word, input int nd, input int de, input bit p_on,
                                input bit pbit, input int ns, input bit s1, input bit s2);
    rx = 1'b0;
    repeat (de) @(negedge clk);
    clk_div         = 16'($urandom);
    bits_per_word   = 5'($urandom);
    parity_en       = 1'($urandom);
    parity_evan_odd = 1'($urandom);
    two_stop_bit    = 1'($urandom);
    for (int i = 0; i < nd; i++) begin
      rx = word[i];
      repeat (de) @(negedge clk);
    end
    if (p_on) begin
      rx = pbit;
      repeat (de) @(negedge clk);
    end
    rx = s1;
    repeat (de) @(negedge clk);
    if (ns == 2) begin
      rx = s2;
      repeat (de) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic run_frame(input string tag, input logic [15:0] word, input logic [4:0] bpw,
                           input logic [15:0] div, input bit pen, input bit podd, input bit pbit,
                           input bit two, input bit s1, input bit s2);
    int          nd, de, ns, exp_busy;
    bit          p_on, exp_ferr, exp_perr;
    logic [31:0] mask;
    logic [15:0] exp_data;
    de = (div < 16'd4) ? 4 : int'(div);
    nd = (bpw < 5'd4) ? 5 : (bpw > 5'd15) ? 16 : int'(bpw) + 1;
    mask = (32'd1 << nd) - 32'd1;
    exp_data = word & mask[15:0];
`ifdef UART_RX_PARITY_EN
    p_on = pen;
`else
    p_on = 1'b0;
`endif
    ns = two ? 2 : 1;
    exp_ferr = !s1 || (ns == 2 && !s2);
    exp_perr = p_on && ((($countones(exp_data) % 2) == 1) ^ pbit ^ podd);
    exp_busy = de / 2 + (nd + int'(p_on) + ns) * de + 1;
    clk_div         = div;
    bits_per_word   = bpw;
    parity_en       = pen;
    parity_evan_odd = podd;
    two_stop_bit    = two;
    rx              = 1'b1;
    repeat (4) @(negedge clk);
    busy_cnt  = 0;
    pulse_cnt = 0;
    apply_stimulus(word, nd, de, p_on, pbit, ns, s1, s2);
    repeat (de + 8) @(negedge clk);
    check_output({tag, ".data"}, 32'(data_out), 32'(exp_data));
    check_output({tag, ".pulses"}, pulse_cnt, 1);
    check_output({tag, ".ferr"}, 32'(frame_error), 32'(exp_ferr));
    check_output({tag, ".perr"}, 32'(parity_error), 32'(exp_perr));
    check_output({tag, ".busy_cycles"}, busy_cnt, exp_busy);
    last_data = exp_data;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_output("reset.busy", 32'(busy), 0);
    check_output("reset.new_data", 32'(new_data), 0);
    check_output("reset.data_out", 32'(data_out), 0);
    check_output("reset.frame_error", 32'(frame_error), 0);
    check_output("reset.parity_error", 32'(parity_error), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    run_frame("8N1_A5", 16'h00A5, 5'd7, 16'd16, 0, 0, 0, 0, 1, 1);
    check_output("8N1_A5.busy153", busy_cnt, 153);
    check_output("8N1_A5.value", 32'(data_out), 32'h00A5);

`ifdef UART_RX_PARITY_EN
    run_frame("8E1_good", 16'h0003, 5'd7, 16'd16, 1, 0, 0, 0, 1, 1);
    check_output("8E1_good.perr0", 32'(parity_error), 0);
    run_frame("8E1_bad", 16'h0003, 5'd7, 16'd16, 1, 0, 1, 0, 1, 1);
    check_output("8E1_bad.perr1", 32'(parity_error), 1);
    check_output("8E1_bad.value", 32'(data_out), 32'h0003);
`else
    run_frame("par_ignored", 16'h0003, 5'd7, 16'd16, 1, 0, 1, 0, 1, 1);
    check_output("par_ignored.perr0", 32'(parity_error), 0);
`endif

    run_frame("8N2_stop2low", 16'h005A, 5'd7, 16'd12, 0, 0, 0, 1, 1, 0);
    repeat (50) @(negedge clk);
    check_output("8N2.ferr_hold", 32'(frame_error), 1);
    run_frame("8N2_clean", 16'h00C3, 5'd7, 16'd12, 0, 0, 0, 1, 1, 1);

    clk_div   = 16'd16;
    busy_cnt  = 0;
    pulse_cnt = 0;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check_output("glitch.busy_pulsed", 32'(busy_cnt > 0), 1);
    check_output("glitch.no_new_data", pulse_cnt, 0);
    check_output("glitch.data_kept", 32'(data_out), 32'(last_data));

    run_frame("5N1_1F", 16'h001F, 5'd4, 16'd16, 0, 0, 0, 0, 1, 1);
    check_output("5N1_1F.value", 32'(data_out), 32'h001F);
    run_frame("clamp_low", 16'hFFE7, 5'd1, 16'd2, 0, 0, 0, 0, 1, 1);
    run_frame("clamp_high", 16'h1234, 5'd31, 16'd10, 0, 0, 0, 0, 1, 1);
    run_frame("16N1_BEEF", 16'hBEEF, 5'd15, 16'd16, 0, 0, 0, 0, 1, 1);
    check_output("16N1_BEEF.value", 32'(data_out), 32'hBEEF);

    clk_div         = 16'd16;
    bits_per_word   = 5'd7;
    parity_en       = 1'b0;
    two_stop_bit    = 1'b0;
    pulse_cnt       = 0;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (16) @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (16) @(negedge clk);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("midreset.busy", 32'(busy), 0);
    check_output("midreset.new_data", 32'(new_data), 0);
    check_output("midreset.data_out", 32'(data_out), 0);
    check_output("midreset.frame_error", 32'(frame_error), 0);
    check_output("midreset.parity_error", 32'(parity_error), 0);
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check_output("midreset.no_new_data", pulse_cnt, 0);
    run_frame("after_reset_3C", 16'h003C, 5'd7, 16'd16, 0, 0, 0, 0, 1, 1);

    for (int n = 0; n < 8; n++) begin
      run_frame($sformatf("rand%0d", n), 16'($urandom), 5'($urandom_range(0, 31)),
                16'($urandom_range(6, 40)), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
